// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state type and access-error check for the data-memory responder
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam logic [2:0] F3_B = 3'd0;
  localparam logic [2:0] F3_H = 3'd1;
  localparam logic [2:0] F3_W = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  // Halves are funct3 1/5 and words 2 (6 is already illegal), so funct3[1:0] gives the width
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] depth);
    return (we ? f3 > F3_W : (f3 == 3'd3 || f3[2:1] == 2'b11)) ||
           (f3[1:0] == F3_H[1:0] && addr[0]) ||
           (f3[1:0] == F3_W[1:0] && addr[1:0] != 2'd0) ||
           ({2'b00, addr[31:2]} >= depth);
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-enables and lane replication for stores, lane extraction and extension for loads
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]        f3,
  input  logic [1:0]        off,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rword,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] wword,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] sh;
  assign sh = rword >> {off, 3'b000};
  assign be = f3[1:0] == F3_B[1:0] ? 4'b0001 << off :
              f3[1:0] == F3_H[1:0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wword = f3[1:0] == F3_B[1:0] ? {4{wdata[7:0]}} :
                 f3[1:0] == F3_H[1:0] ? {2{wdata[15:0]}} : wdata;
  assign rdata = f3[1:0] == F3_B[1:0] ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
                 f3[1:0] == F3_H[1:0] ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : rword;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable latency over an
// inferred word RAM, handling RV32I byte/half/word loads and stores with error detection
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic r_we;
  logic [2:0] r_f3;
  logic [AW+1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic accept, err, access, a_we;
  logic [2:0] a_f3;
  logic [AW+1:0] a_addr;
  logic [WORD_W-1:0] a_wdata, wword, ld_data;
  logic [3:0] be;
  assign req_ready = reset && state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  assign err = access_err(req_we, req_funct3, req_addr, 32'(DEPTH_WORDS));
  // With zero wait the access happens on the accept edge, straight from the request inputs
  assign a_we = state == IDLE ? req_we : r_we;
  assign a_f3 = state == IDLE ? req_funct3 : r_f3;
  assign a_addr = state == IDLE ? req_addr[AW+1:0] : r_addr;
  assign a_wdata = state == IDLE ? req_wdata : r_wdata;
  assign access = state == IDLE ? accept && !err && WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd0;
  dmem_lane_align u_align (
    .f3(a_f3),
    .off(a_addr[1:0]),
    .wdata(a_wdata),
    .rword(mem[a_addr[AW+1:2]]),
    .be(be),
    .wword(wword),
    .rdata(ld_data)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? (err || WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;
      WAIT: state_nx = cnt == 4'd0 ? RESP : WAIT;
      RESP: state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      r_we <= 1'b0;
      r_f3 <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        r_we <= req_we;
        r_f3 <= req_funct3;
        r_addr <= req_addr[AW+1:0];
        r_wdata <= req_wdata;
        cnt <= 4'(WAIT_CYCLES - 1);
        rsp_err <= err;
        rsp_rdata <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access) rsp_rdata <= a_we ? '0 : ld_data;
    end
  end
  always_ff @(posedge clk) begin
    if (access && a_we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[a_addr[AW+1:2]][8*b +: 8] <= wword[8*b +: 8];
  end
endmodule
